// File: rtl/ecdsa_arith_pkg.sv
// Shared types and defaults for the ECDSA modular arithmetic engine.
package ecdsa_arith_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_INV = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_ADDSUB,
    S_MUL,
    S_INV,
    S_DONE
  } state_e;

  // Binary extended Euclid needs at most about two halvings per operand bit.
  function automatic int inv_max_default(input int width);
    return 4 * width;
  endfunction

endpackage

// File: rtl/ecdsa_mod_arith_addsub.sv
// Combinational (x + y) mod n or (x - y) mod n for operands already reduced below n.
module mod_addsub #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [WIDTH-1:0] n,
  input  logic             sub,
  output logic [WIDTH-1:0] r
);

  logic [WIDTH:0] s;
  logic [WIDTH:0] d;

  always_comb begin
    s = {1'b0, x} + {1'b0, y};
    d = {1'b0, x} - {1'b0, y};
    if (sub)
      r = d[WIDTH] ? d[WIDTH-1:0] + n : d[WIDTH-1:0];
    else
      r = (s >= {1'b0, n}) ? s[WIDTH-1:0] - n : s[WIDTH-1:0];
  end

endmodule

// File: rtl/ecdsa_mod_arith.sv
// Multi-cycle modular add/sub/mul/inverse engine shared by the ECDSA sign and verify FSMs.
// Build option: ECDSA_CONST_TIME_EN makes INV and CHECK-error timing independent of data.
//
// state    | meaning
// IDLE     | ready=1, waiting for go
// CHECK    | validate modulus/operands, set up the selected operation
// ADDSUB   | single-cycle modular add or subtract
// MUL      | MSB-first double-and-add, one bit of a per cycle
// INV      | binary extended Euclid, one step per cycle
// DONE     | done pulse, result/error valid
module ecdsa_mod_arith
  import ecdsa_arith_pkg::*;
#(
  parameter int WIDTH   = 64,
  parameter int INV_MAX = inv_max_default(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] n,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             error
);

`ifdef ECDSA_CONST_TIME_EN
  localparam bit CONST_TIME = 1'b1;
`else
  localparam bit CONST_TIME = 1'b0;
`endif

  localparam int CNT_MAX = (INV_MAX > WIDTH) ? INV_MAX : WIDTH;
  localparam int CW = $clog2(CNT_MAX + 1);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_e           state;
  op_e              op_r;
  logic [WIDTH-1:0] u, v, b_r, n_r, x1, x2;
  logic [CW-1:0]    cnt;
  logic             err_r, fin;

  logic [WIDTH-1:0] p_x, p_y, p_r, q_r, mul_next, inv_res, sel_x;
  logic             p_sub, chk_err, u_one, v_one, inv_hit, inv_err, sel_err, fin_now;

  function automatic logic [WIDTH-1:0] half_mod(input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] m);
    if (x[0]) return WIDTH'(({1'b0, x} + {1'b0, m}) >> 1);
    else      return x >> 1;
  endfunction

  // u/x1 double as the multiplier shift register and accumulator during MUL.
  always_comb begin
    p_x   = u;
    p_y   = b_r;
    p_sub = (op_r == OP_SUB);
    case (state)
      S_MUL: begin
        p_x   = x1;
        p_y   = x1;
        p_sub = 1'b0;
      end
      S_INV: begin
        p_x   = (u >= v) ? x1 : x2;
        p_y   = (u >= v) ? x2 : x1;
        p_sub = 1'b1;
      end
      default: ;
    endcase
  end

  mod_addsub #(.WIDTH(WIDTH)) u_primary (
    .x(p_x), .y(p_y), .n(n_r), .sub(p_sub), .r(p_r)
  );

  mod_addsub #(.WIDTH(WIDTH)) u_mul_add (
    .x(p_r), .y(b_r), .n(n_r), .sub(1'b0), .r(q_r)
  );

  always_comb begin
    mul_next = u[WIDTH-1] ? q_r : p_r;
    chk_err  = (n_r <= ONE) || ((op_r == OP_INV) && (!n_r[0] || (u == '0)));
    u_one    = (u == ONE);
    v_one    = (v == ONE);
    inv_hit  = u_one || v_one || (u == '0) || (v == '0);
    inv_err  = !(u_one || v_one);
    inv_res  = u_one ? x1 : (v_one ? x2 : '0);
    fin_now  = fin || inv_hit;
    sel_x    = fin ? x1 : inv_res;
    sel_err  = fin ? err_r : inv_err;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= S_IDLE;
      op_r   <= OP_ADD;
      u      <= '0;
      v      <= '0;
      b_r    <= '0;
      n_r    <= '0;
      x1     <= '0;
      x2     <= '0;
      cnt    <= '0;
      err_r  <= 1'b0;
      fin    <= 1'b0;
      ready  <= 1'b1;
      done   <= 1'b0;
      result <= '0;
      error  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (go) begin
            op_r   <= op_e'(op);
            u      <= a;
            b_r    <= b;
            n_r    <= n;
            ready  <= 1'b0;
            result <= '0;
            error  <= 1'b0;
            state  <= S_CHECK;
          end
        end
        S_CHECK: begin
          err_r <= chk_err;
          fin   <= chk_err;
          if (chk_err && !CONST_TIME) begin
            result <= '0;
            error  <= 1'b1;
            done   <= 1'b1;
            state  <= S_DONE;
          end else begin
            case (op_r)
              OP_ADD, OP_SUB: state <= S_ADDSUB;
              OP_MUL: begin
                x1    <= '0;
                cnt   <= CW'(WIDTH);
                state <= S_MUL;
              end
              default: begin
                v     <= n_r;
                x1    <= ONE;
                x2    <= '0;
                cnt   <= CW'(INV_MAX);
                state <= S_INV;
              end
            endcase
          end
        end
        S_ADDSUB: begin
          result <= err_r ? '0 : p_r;
          error  <= err_r;
          done   <= 1'b1;
          state  <= S_DONE;
        end
        S_MUL: begin
          if (cnt == '0) begin
            result <= err_r ? '0 : x1;
            error  <= err_r;
            done   <= 1'b1;
            state  <= S_DONE;
          end else begin
            cnt <= cnt - 1'b1;
            x1  <= mul_next;
            u   <= u << 1;
          end
        end
        S_INV: begin
          if (!CONST_TIME && inv_hit) begin
            result <= inv_res;
            error  <= inv_err;
            done   <= 1'b1;
            state  <= S_DONE;
          end else if (cnt == '0) begin
            // Step budget exhausted: only a guard for illegal or pathological inputs.
            result <= (fin_now && !sel_err) ? sel_x : '0;
            error  <= fin_now ? sel_err : 1'b1;
            done   <= 1'b1;
            state  <= S_DONE;
          end else begin
            cnt <= cnt - 1'b1;
            if (fin) begin
            end else if (inv_hit) begin
              x1    <= inv_res;
              err_r <= inv_err;
              fin   <= 1'b1;
            end else if (!u[0]) begin
              u  <= u >> 1;
              x1 <= half_mod(x1, n_r);
            end else if (!v[0]) begin
              v  <= v >> 1;
              x2 <= half_mod(x2, n_r);
            end else if (u >= v) begin
              u  <= u - v;
              x1 <= p_r;
            end else begin
              v  <= v - u;
              x2 <= p_r;
            end
          end
        end
        S_DONE: begin
          ready <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ecdsa_mod_arith.sv
// Self-checking bench for ecdsa_mod_arith: arithmetic reference model plus directed vectors.
module tb_ecdsa_mod_arith;

  localparam int W    = 16;
  localparam int IMAX = 4 * W;

`ifdef ECDSA_CONST_TIME_EN
  localparam bit CT = 1'b1;
`else
  localparam bit CT = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         go  = 1'b0;
  logic [1:0]   op  = 2'd0;
  logic [W-1:0] a   = '0;
  logic [W-1:0] b   = '0;
  logic [W-1:0] n   = '0;
  logic         ready, done, error;
  logic [W-1:0] result;

  ecdsa_mod_arith #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .go(go), .op(op), .a(a), .b(b), .n(n),
    .ready(ready), .done(done), .result(result), .error(error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int last_lat = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at t=%0t",
                  name, act, act, exp, exp, $time);
  endtask

  typedef struct {
    logic [W-1:0] res;
    logic         err;
    int           lat;
    int           t_acc;
  } exp_t;

  exp_t q[$];

  // Reference: plain modular arithmetic, standard extended Euclid for the inverse.
  function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] xa, xb, xn, input int t);
    exp_t e;
    longint A, B, N, r0, r1, t0, t1, qq, tmp;
    A = longint'(xa); B = longint'(xb); N = longint'(xn);
    e.t_acc = t; e.res = '0; e.err = 1'b0; e.lat = -1;
    if (N < 2 || (o == 2'd3 && (N % 2 == 0 || A == 0))) begin
      e.err = 1'b1;
      if (!CT) e.lat = 2;
      else e.lat = (o == 2'd3) ? IMAX + 3 : (o == 2'd2) ? W + 3 : 3;
      return e;
    end
    case (o)
      2'd0: begin e.res = W'((A + B) % N);     e.lat = 3; end
      2'd1: begin e.res = W'((A + N - B) % N); e.lat = 3; end
      2'd2: begin e.res = W'((A * B) % N);     e.lat = W + 3; end
      default: begin
        r0 = N; r1 = A; t0 = 0; t1 = 1;
        while (r1 != 0) begin
          qq = r0 / r1;
          tmp = r0 - qq * r1; r0 = r1; r1 = tmp;
          tmp = t0 - qq * t1; t0 = t1; t1 = tmp;
        end
        if (r0 != 1) e.err = 1'b1;
        else e.res = W'(((t0 % N) + N) % N);
        e.lat = CT ? IMAX + 3 : -1;
      end
    endcase
    return e;
  endfunction

  // Single compare process: handshake and every completed result against the model.
  always @(negedge clk) begin
    if (rst) begin
      exp_t e;
      chk("ready", ready, (q.size() == 0));
      if (done) begin
        chk("done_expected", done, (q.size() != 0));
        if (q.size() != 0) begin
          e = q.pop_front();
          last_lat = cyc - e.t_acc;
          chk("result", result, e.res);
          chk("error", error, e.err);
          if (e.lat >= 0) chk("latency", last_lat, e.lat);
        end
      end
      if (go && ready) q.push_back(model(op, a, b, n, cyc));
    end
  end

  task automatic issue(input logic [1:0] o, input logic [W-1:0] xa, xb, xn);
    int k = 0;
    @(posedge clk); #1;
    while (!ready && k < 2000) begin @(posedge clk); #1; k++; end
    chk("ready_wait", ready, 1);
    go = 1'b1; op = o; a = xa; b = xb; n = xn;
    @(posedge clk); #1;
    go = 1'b0;
  endtask

  task automatic wait_done();
    int k = 0;
    while (!done && k < 2000) begin @(posedge clk); #1; k++; end
    chk("done_seen", done, 1);
    @(negedge clk); #1;
  endtask

  task automatic run(input logic [1:0] o, input logic [W-1:0] xa, xb, xn);
    issue(o, xa, xb, xn);
    wait_done();
  endtask

  logic [W-1:0] primes [8] = '{16'd7, 16'd13, 16'd97, 16'd251, 16'd257, 16'd1021, 16'd32749, 16'd65521};
  int lat1, lat3;

  initial begin
    #13;
    chk("rst_ready", ready, 1);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_error", error, 0);
    rst = 1'b1;

    run(2'd0, 16'd5, 16'd4, 16'd7);
    chk("add_5_4_mod7", result, 2);
    chk("add_lat", last_lat, 3);
    run(2'd1, 16'd2, 16'd5, 16'd7);
    chk("sub_2_5_mod7", result, 4);

    run(2'd2, 16'd3, 16'd5, 16'd7);
    chk("mul_3_5_mod7", result, 1);
    run(2'd2, 16'd6, 16'd6, 16'd7);
    chk("mul_6_6_mod7", result, 1);
    run(2'd2, 16'd65520, 16'd65519, 16'd65521);
    chk("mul_big", result, 2);

    run(2'd3, 16'd3, 16'd0, 16'd7);
    chk("inv_3_mod7", result, 5);
    lat3 = last_lat;
    run(2'd3, 16'd1, 16'd0, 16'd7);
    chk("inv_1_mod7", result, 1);
    lat1 = last_lat;
    if (CT) chk("inv_const_time", lat1, lat3);
    else begin
      chk("inv_a1_lat", lat1, 3);
      chk("inv_a1_earlier", (lat1 < lat3), 1);
    end

    run(2'd3, 16'd0, 16'd0, 16'd7);
    chk("inv_a0_err", error, 1);
    chk("inv_a0_res", result, 0);
    run(2'd3, 16'd2, 16'd0, 16'd6);
    chk("inv_even_n_err", error, 1);
    run(2'd0, 16'd0, 16'd0, 16'd1);
    chk("add_n1_err", error, 1);
    chk("add_n1_lat", last_lat, CT ? 3 : 2);
    run(2'd3, 16'd6, 16'd0, 16'd9);
    chk("inv_gcd3_err", error, 1);

    for (int i = 0; i < 8; i++) begin
      logic [W-1:0] ra;
      ra = W'($urandom_range(1, int'(primes[i]) - 1));
      run(2'd3, ra, 16'd0, primes[i]);
      chk("inv_rand_prod", (longint'(ra) * longint'(result)) % longint'(primes[i]), 1);
    end

    issue(2'd2, 16'd4, 16'd5, 16'd7);
    repeat (3) @(posedge clk);
    #1; go = 1'b1; op = 2'd0; a = 16'd1; b = 16'd1; n = 16'd7;
    @(posedge clk); #1; go = 1'b0;
    wait_done();
    chk("mul_busy_go", result, 6);
    repeat (W + 5) @(posedge clk);
    #1;

    issue(2'd3, 16'd3, 16'd0, 16'd65521);
    repeat (5) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("arst_ready", ready, 1);
    chk("arst_done", done, 0);
    chk("arst_result", result, 0);
    chk("arst_error", error, 0);
    q.delete();
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    repeat (IMAX + 10) @(posedge clk);
    #1;
    run(2'd3, 16'd3, 16'd0, 16'd7);
    chk("inv_after_rst", result, 5);
    repeat (3) @(posedge clk);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
